// File: rtl/riscv_ex_pkg.sv
// riscv_ex_pkg: shared encodings for the RV32IM execute stage
package riscv_ex_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
   } alu_op_t;
   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_t;
   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
endpackage

// File: rtl/execute_stage_muldiv.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider on magnitudes,
// with the sign applied once at the end and divide corner cases resolved at launch.
module muldiv_unit
   import riscv_ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            md_en,
   input  md_op_t          md_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_t state, state_n;
   md_op_t op;
   logic [CW-1:0] count;
   logic neg;
   logic [XLEN-1:0] divisor, hi, lo;
   logic sgn_a, sgn_b, sa, sb, neg_n, div0, ovf, special, last, ge;
   logic [XLEN-1:0] abs_a, abs_b, special_res, mul_hi, mul_lo, div_hi, div_lo;
   logic [XLEN-1:0] step_hi, step_lo, q, r, mul_res, fin;
   logic [XLEN:0] sum, t;
   logic [2*XLEN-1:0] prod, prod_fix;

   assign sgn_a   = !(md_op == MD_MULHU || md_op == MD_DIVU || md_op == MD_REMU);
   assign sgn_b   = sgn_a && md_op != MD_MULHSU;
   assign sa      = sgn_a & src_a[XLEN-1];
   assign sb      = sgn_b & src_b[XLEN-1];
   assign abs_a   = sa ? -src_a : src_a;
   assign abs_b   = sb ? -src_b : src_b;
   // a remainder takes the dividend's sign, everything else the product of signs
   assign neg_n   = (md_op[2] & md_op[1]) ? sa : sa ^ sb;
   assign div0    = md_op[2] && src_b == '0;
   assign ovf     = md_op[2] && !md_op[0] && src_a == MIN && src_b == '1;
   assign special = div0 | ovf;
   assign special_res = div0 ? (md_op[1] ? src_a : '1) : (md_op[1] ? '0 : MIN);

   assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
   assign mul_hi  = sum[XLEN:1];
   assign mul_lo  = {sum[0], lo[XLEN-1:1]};
   assign t       = {hi, lo[XLEN-1]};
   assign ge      = t >= {1'b0, divisor};
   assign div_hi  = ge ? t[XLEN-1:0] - divisor : t[XLEN-1:0];
   assign div_lo  = {lo[XLEN-2:0], ge};
   assign step_hi = op[2] ? div_hi : mul_hi;
   assign step_lo = op[2] ? div_lo : mul_lo;

   assign prod     = {step_hi, step_lo};
   assign prod_fix = neg ? -prod : prod;
   assign mul_res  = (op == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   assign q        = neg ? -step_lo : step_lo;
   assign r        = neg ? -step_hi : step_hi;
   assign fin      = op[2] ? (op[1] ? r : q) : mul_res;
   assign last     = count == CW'(MD_CYCLES - 1);

   assign busy = (state == MD_IDLE && md_en) || state == MD_RUN;
   assign done = state == MD_DONE;

   always_comb begin
      state_n = state;
      case (state)
         MD_IDLE: state_n = md_en ? (special ? MD_DONE : MD_RUN) : MD_IDLE;
         MD_RUN:  state_n = last ? MD_DONE : MD_RUN;
         default: state_n = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk)
      state <= reset ? MD_IDLE : state_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         op      <= MD_MUL;
         count   <= '0;
         neg     <= 1'b0;
         divisor <= '0;
         hi      <= '0;
         lo      <= '0;
         result  <= '0;
      end else if (state == MD_IDLE && md_en) begin
         op      <= md_op;
         count   <= '0;
         neg     <= neg_n;
         divisor <= abs_b;
         hi      <= '0;
         lo      <= abs_a;
         if (special) result <= special_res;
      end else if (state == MD_RUN) begin
         hi    <= step_hi;
         lo    <= step_lo;
         count <= count + 1'b1;
         if (last) result <= fin;
      end
   end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU, branch resolution and target generation;
// M-extension ops are delegated to muldiv_unit, which stalls the pipe while busy.
module execute_stage
   import riscv_ex_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] rd1_e,
   input  logic [XLEN-1:0] rd2_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] imm_ext_e,
   input  logic [XLEN-1:0] pc_plus4_e,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [XLEN-1:0] result_w,
   input  logic [1:0]      forward_a_e,
   input  logic [1:0]      forward_b_e,
   input  logic [3:0]      alu_control_e,
   input  logic            alu_src_e,
   input  logic            branch_e,
   input  logic            jump_e,
   input  logic            jalr_e,
   input  logic [2:0]      funct3_e,
   input  logic            md_en_e,
   input  logic [2:0]      md_op_e,
   output logic [XLEN-1:0] alu_result_e,
   output logic [XLEN-1:0] write_data_e,
   output logic [XLEN-1:0] pc_target_e,
   output logic            pc_src_e,
   output logic            md_busy_e
);
   localparam int SW = $clog2(XLEN);

   logic [XLEN-1:0] src_a, fwd_b, src_b, alu_out, jalr_sum, md_result;
   logic [SW-1:0] shamt;
   logic cond, md_done, unused_pc_plus4;

   // PC+4 is carried to writeback by the later pipeline registers, not used here
   assign unused_pc_plus4 = ^pc_plus4_e;

   assign src_a = forward_a_e == FWD_W ? result_w : forward_a_e == FWD_M ? alu_result_m : rd1_e;
   assign fwd_b = forward_b_e == FWD_W ? result_w : forward_b_e == FWD_M ? alu_result_m : rd2_e;
   assign src_b = alu_src_e ? imm_ext_e : fwd_b;
   assign write_data_e = fwd_b;
   assign shamt = src_b[SW-1:0];

   always_comb begin
      alu_out = '0;
      case (alu_op_t'(alu_control_e))
         ALU_ADD:   alu_out = src_a + src_b;
         ALU_SUB:   alu_out = src_a - src_b;
         ALU_AND:   alu_out = src_a & src_b;
         ALU_OR:    alu_out = src_a | src_b;
         ALU_XOR:   alu_out = src_a ^ src_b;
         ALU_SLT:   alu_out = XLEN'($signed(src_a) < $signed(src_b));
         ALU_SLTU:  alu_out = XLEN'(src_a < src_b);
         ALU_SLL:   alu_out = src_a << shamt;
         ALU_SRL:   alu_out = src_a >> shamt;
         ALU_SRA:   alu_out = $signed(src_a) >>> shamt;
         ALU_PASSB: alu_out = src_b;
         default:   alu_out = '0;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (funct3_e)
         F3_BEQ:  cond = src_a == fwd_b;
         F3_BNE:  cond = src_a != fwd_b;
         F3_BLT:  cond = $signed(src_a) < $signed(fwd_b);
         F3_BGE:  cond = $signed(src_a) >= $signed(fwd_b);
         F3_BLTU: cond = src_a < fwd_b;
         F3_BGEU: cond = src_a >= fwd_b;
         default: cond = 1'b0;
      endcase
   end

   assign jalr_sum     = src_a + imm_ext_e;
   assign pc_target_e  = jalr_e ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : pc_e + imm_ext_e;
   assign pc_src_e     = jump_e | (branch_e & cond);
   assign alu_result_e = md_done ? md_result : alu_out;

   muldiv_unit #(.XLEN(XLEN), .MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .md_en  (md_en_e),
      .md_op  (md_op_t'(md_op_e)),
      .src_a  (src_a),
      .src_b  (src_b),
      .busy   (md_busy_e),
      .done   (md_done),
      .result (md_result)
   );
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed checks of forwarding, ALU, branches and the M unit
module tb_execute_stage;
   import riscv_ex_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e, alu_result_m, result_w;
   logic [1:0] forward_a_e, forward_b_e;
   logic [3:0] alu_control_e;
   logic alu_src_e, branch_e, jump_e, jalr_e, md_en_e;
   logic [2:0] funct3_e, md_op_e;
   logic [31:0] alu_result_e, write_data_e, pc_target_e;
   logic pc_src_e, md_busy_e;
   int passed = 0, failed = 0, total = 0;
   int cyc;
   logic [31:0] res;

   execute_stage dut (
      .clk(clk), .reset(reset), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
      .imm_ext_e(imm_ext_e), .pc_plus4_e(pc_plus4_e), .alu_result_m(alu_result_m),
      .result_w(result_w), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
      .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .md_en_e(md_en_e),
      .md_op_e(md_op_e), .alu_result_e(alu_result_e), .write_data_e(write_data_e),
      .pc_target_e(pc_target_e), .pc_src_e(pc_src_e), .md_busy_e(md_busy_e)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launches one M op; srcA optionally arrives through the M-stage forward path,
   // which is then disturbed to show it is sampled only at launch.
   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fwd_m, output int n, output logic [31:0] r);
      forward_a_e = fwd_m ? FWD_M : FWD_REG;
      alu_result_m = a;
      rd1_e = fwd_m ? 32'h0 : a;
      rd2_e = b;
      md_op_e = op;
      md_en_e = 1'b1;
      #1;
      n = 0;
      while (md_busy_e && n < 60) begin
         n++;
         tick();
         alu_result_m = 32'h1234_5678;
      end
      r = alu_result_e;
      md_en_e = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      {rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e, alu_result_m, result_w} = '0;
      {forward_a_e, forward_b_e, alu_control_e, alu_src_e} = '0;
      {branch_e, jump_e, jalr_e, funct3_e, md_en_e, md_op_e} = '0;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("reset alu_result", alu_result_e, 32'h0);
      check("reset pc_target", pc_target_e, 32'h0);
      check("reset pc_src", {31'b0, pc_src_e}, 32'h0);
      check("reset busy", {31'b0, md_busy_e}, 32'h0);

      forward_a_e = FWD_M; alu_result_m = 32'd5; rd2_e = 32'd7; alu_control_e = ALU_ADD;
      #1;
      check("add fwd_m", alu_result_e, 32'd12);
      check("add busy", {31'b0, md_busy_e}, 32'h0);

      forward_a_e = FWD_REG; rd1_e = 32'd3; forward_b_e = FWD_W; result_w = 32'd10;
      alu_control_e = ALU_SUB;
      #1;
      check("sub fwd_w", alu_result_e, 32'hFFFF_FFF9);
      check("store data fwd_w", write_data_e, 32'd10);

      forward_b_e = FWD_REG; rd1_e = 32'h8000_0000; alu_src_e = 1'b1; imm_ext_e = 32'd4;
      alu_control_e = ALU_SRA;
      #1;
      check("sra", alu_result_e, 32'hF800_0000);
      alu_control_e = ALU_SLTU; rd1_e = 32'd3;
      #1;
      check("sltu", alu_result_e, 32'd1);
      alu_control_e = 4'd15;
      #1;
      check("undefined op", alu_result_e, 32'h0);
      alu_control_e = ALU_PASSB; imm_ext_e = 32'hABCD_E000;
      #1;
      check("passb lui", alu_result_e, 32'hABCD_E000);

      alu_src_e = 1'b0; alu_control_e = ALU_ADD; rd1_e = 32'hFFFF_FFFF; rd2_e = 32'd1;
      branch_e = 1'b1; funct3_e = F3_BLT; pc_e = 32'h100; imm_ext_e = 32'h20;
      #1;
      check("blt taken", {31'b0, pc_src_e}, 32'd1);
      check("blt target", pc_target_e, 32'h120);
      funct3_e = F3_BGE;
      #1;
      check("bge not taken", {31'b0, pc_src_e}, 32'd0);
      funct3_e = F3_BGEU;
      #1;
      check("bgeu taken", {31'b0, pc_src_e}, 32'd1);
      funct3_e = 3'b010;
      #1;
      check("bad funct3", {31'b0, pc_src_e}, 32'd0);

      branch_e = 1'b0; jump_e = 1'b1; jalr_e = 1'b1; rd1_e = 32'h1003; imm_ext_e = 32'h0;
      #1;
      check("jalr target", pc_target_e, 32'h1002);
      check("jalr pc_src", {31'b0, pc_src_e}, 32'd1);
      jump_e = 1'b0; jalr_e = 1'b0; funct3_e = 3'b000; pc_e = 32'h0;

      run_md(MD_MULH, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc, res);
      check("mulh busy cycles", 32'(cyc), 32'd33);
      check("mulh result", res, 32'hFFFF_FFFF);
      run_md(MD_MUL, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc, res);
      check("mul result", res, 32'hFFFF_FFFA);
      run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, res);
      check("mulhsu result", res, 32'hFFFF_FFFF);
      run_md(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, res);
      check("mulhu result", res, 32'hFFFF_FFFE);
      run_md(MD_DIV, 32'd7, 32'd0, 1'b0, cyc, res);
      check("div0 busy cycles", 32'(cyc), 32'd1);
      check("div0 result", res, 32'hFFFF_FFFF);
      run_md(MD_REMU, 32'd7, 32'd0, 1'b0, cyc, res);
      check("remu0 result", res, 32'd7);
      run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, res);
      check("rem ovf busy cycles", 32'(cyc), 32'd1);
      check("rem ovf result", res, 32'h0);
      run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, res);
      check("div ovf result", res, 32'h8000_0000);
      run_md(MD_DIVU, 32'd100, 32'd7, 1'b1, cyc, res);
      check("divu busy cycles", 32'(cyc), 32'd33);
      check("divu fwd result", res, 32'd14);
      run_md(MD_REMU, 32'd100, 32'd7, 1'b0, cyc, res);
      check("remu result", res, 32'd2);
      run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, res);
      check("div neg result", res, 32'hFFFF_FFFD);
      run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, res);
      check("rem neg result", res, 32'hFFFF_FFFF);

      forward_a_e = FWD_REG; rd1_e = 32'd100; rd2_e = 32'd7; md_op_e = MD_DIVU; md_en_e = 1'b1;
      tick();
      repeat (10) tick();
      check("busy mid-run", {31'b0, md_busy_e}, 32'd1);
      reset = 1'b1; md_en_e = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      check("abort busy", {31'b0, md_busy_e}, 32'd0);
      check("abort alu passthrough", alu_result_e, 32'd107);
      run_md(MD_DIVU, 32'd9, 32'd3, 1'b0, cyc, res);
      check("post-abort busy cycles", 32'(cyc), 32'd33);
      check("post-abort divu", res, 32'd3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline, directly downstream of the decode/execute pipeline register. Consumes its outputs (operands, immediate, PC values).
- Applies forwarding, computes the ALU result and the branch/jump target, and resolves pc_src.
- Runs M-extension ops on an iterative multiply/divide unit and holds the pipeline via md_busy_e while that unit runs.
- Outputs feed the execute/memory register and the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations per multiply/divide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd1_e, rd2_e  in  XLEN  register operands from decode/execute register
- pc_e, imm_ext_e, pc_plus4_e  in  XLEN  PC, extended immediate, PC+4
- alu_result_m  in  XLEN  forward source, memory stage
- result_w  in  XLEN  forward source, writeback stage
- forward_a_e, forward_b_e  in  2  00=reg, 01=result_w, 10=alu_result_m, 11=reg
- alu_control_e  in  4  ALU op (package encoding)
- alu_src_e  in  1  srcB select: 1=imm_ext_e, 0=forwarded rd2
- branch_e, jump_e, jalr_e  in  1  control-flow type
- funct3_e  in  3  branch condition
- md_en_e  in  1  instruction is an M-extension op
- md_op_e  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 order)
- alu_result_e  out  XLEN  ALU result, or M result
- write_data_e  out  XLEN  forwarded rd2 (store data)
- pc_target_e  out  XLEN  branch/jump target
- pc_src_e  out  1  redirect fetch to pc_target_e
- md_busy_e  out  1  stall F/D/E and bubble the execute/memory register

Behaviour:
- srcA = forward mux on rd1_e. fwdB = forward mux on rd2_e. srcB = alu_src_e ? imm_ext_e : fwdB. write_data_e = fwdB.
- ALU: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB (LUI). Shift amount = srcB[4:0]. Undefined codes give 0. Zero latency.
- Branch conditions on srcA vs fwdB: BEQ, BNE, BLT, BGE, BLTU, BGEU. Any other funct3 = not taken.
- pc_src_e = jump_e | (branch_e & cond).
- pc_target_e = jalr_e ? ((srcA + imm_ext_e) & ~1) : (pc_e + imm_ext_e).
- M-unit FSM has three states: IDLE, RUN, DONE.
- IDLE with md_en_e=1:
  - Latch |srcA|, |srcB| and result-sign flags according to op signedness. Clear count.
  - Go to RUN.
  - Divisor 0: go straight to DONE. DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - DIV/REM with 0x80000000 / -1: go straight to DONE. Quotient = 0x80000000, remainder = 0.
- RUN: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle. count increments. After count = MD_CYCLES-1, apply sign fixup, register the result, go to DONE.
- DONE: alu_result_e = registered M result, md_busy_e = 0. Go to IDLE unconditionally. The same instruction is not restarted because the decode/execute register advances at this edge.
- md_busy_e = (IDLE & md_en_e) | RUN. This is combinational so the decode/execute register holds in the launch cycle.
- Latency: a normal M op spends MD_CYCLES+2 cycles in execute (34 by default). A special-case divide spends 2.
- MUL returns the low 32 bits. MULH, MULHSU and MULHU return the high 32 bits of the 64-bit product.
- Forward inputs are sampled only in the IDLE launch cycle. Later changes in M/W do not affect the result.
- The hazard unit never flushes execute while md_busy_e=1. If reset is asserted mid-operation, abort.
- Reset (synchronous): state = IDLE, count = 0, operand/accumulator/result registers = 0, md_busy_e = 0.
- Outputs are combinational from inputs plus the M result register. With all inputs 0 after reset: alu_result_e = 0, pc_target_e = 0, pc_src_e = 0.

Decomposition:
- Package riscv_ex_pkg holds the alu_op_t enum (4-bit), md_op_t enum (3-bit), md_state_t (IDLE/RUN/DONE), forward-select constants and branch funct3 constants.
- One sub-module, muldiv_unit, contains the FSM, counter, operand/accumulator registers and sign handling.
- execute_stage contains the forwarding, ALU and branch logic and instantiates muldiv_unit.

Test Plan:
- ADD, forward_a=10, alu_result_m=5, rd2_e=7, alu_src=0 -> alu_result_e=12, md_busy_e=0 in the same cycle.
- BLT, srcA=-1, fwdB=1, pc_e=0x100, imm=0x20 -> pc_src_e=1, pc_target_e=0x120.
- JALR, srcA=0x1003, imm=0 -> pc_target_e=0x1002, pc_src_e=1.
- MULH, -2 * 3 with md_en held -> md_busy_e high for 33 cycles, then DONE cycle with alu_result_e=0xFFFFFFFF. MUL on the same operands -> 0xFFFFFFFA.
- DIV 7 / 0 -> busy for 1 cycle, then 0xFFFFFFFF. REM 0x80000000 / -1 -> 0. DIVU 100 / 7 -> 14 after 34 cycles.
- Reset asserted in RUN at count=10 -> next cycle state IDLE, md_busy_e=0. A fresh DIVU 9/3 then returns 3.
